// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline arbiter slice: width helpers and defaults.
// Also used by the response demux and credit logic.
package pipeline_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_REQ    = 4;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // An index field is never narrower than one bit, even for a single requester.
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/pipeline_rr_pick.sv
// Rotating-priority picker: the first valid index at or after ptr, wrapping modulo NUM_REQ.
// Purely combinational.
module pipeline_rr_pick
  import pipeline_pkg::*;
#(
  parameter int NUM_REQ  = DEFAULT_NUM_REQ,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_valid
);

  assign any_valid = |valid;

  // Walk offsets from farthest to nearest, so the nearest valid index is written last and wins.
  // The wrap subtracts NUM_REQ explicitly, which keeps non-power-of-two counts correct.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int                 idx;
      logic [NUM_REQ-1:0] shifted;
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      shifted = valid >> idx;
      if (shifted[0]) winner = ID_WIDTH'(idx);
    end
  end

endmodule

// File: rtl/pipeline_rr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ valid/ready sources into one registered output stage.
// A requester may hold up to BURST_LEN back-to-back grants before priority rotates past it.
module pipeline_rr_arbiter
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int ID_WIDTH   = id_width(NUM_REQ),
  parameter int BURST_LEN  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         d_data,
  output logic [ID_WIDTH-1:0]           d_id,
  output logic                          d_valid,
  input  logic                          d_ready
);

  localparam int CNT_W = id_width(BURST_LEN);

  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   ptr_nxt;
  logic [ID_WIDTH-1:0]   winner;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [CNT_W-1:0]      ec;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  any_valid;
  logic                  load;

  assign load = d_ready | ~d_valid;

  pipeline_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Payload mux and one-hot ready; d_ready reaches req_ready only through load.
  always_comb begin
    win_data  = '0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == ID_WIDTH'(k)) begin
        win_data     = req_data[k*DATA_WIDTH +: DATA_WIDTH];
        req_ready[k] = load & any_valid;
      end
    end
  end

  // The burst count carries over only when the pointed-to requester wins again.
  // Any other winner starts a fresh burst.
  always_comb begin
    ec = (winner == ptr) ? cnt : '0;
    if (ec == CNT_W'(BURST_LEN - 1)) begin
      cnt_nxt = '0;
      ptr_nxt = ((int'(winner) + 1) >= NUM_REQ) ? '0 : winner + 1'b1;
    end else begin
      cnt_nxt = ec + 1'b1;
      ptr_nxt = winner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_data  <= '0;
      d_id    <= '0;
      d_valid <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else if (load) begin
      if (any_valid) begin
        d_data  <= win_data;
        d_id    <= winner;
        d_valid <= 1'b1;
        ptr     <= ptr_nxt;
        cnt     <= cnt_nxt;
      end else begin
        d_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Directed bench: one arbiter built for strict round-robin, one built for bursts of three.
// Every expected value below is worked out by hand.
module tb_pipeline_rr_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic          clk;
  logic          rst;
  logic [NR*DW-1:0] req_data;

  logic [NR-1:0] valid1, ready1;
  logic [DW-1:0] d_data1;
  logic [IW-1:0] d_id1;
  logic          d_valid1, d_ready1;

  logic [NR-1:0] valid3, ready3;
  logic [DW-1:0] d_data3;
  logic [IW-1:0] d_id3;
  logic          d_valid3, d_ready3;

  int nvec;
  int nerr;

  pipeline_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .BURST_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(valid1), .req_ready(ready1),
    .d_data(d_data1), .d_id(d_id1), .d_valid(d_valid1), .d_ready(d_ready1)
  );

  pipeline_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .BURST_LEN(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(valid3), .req_ready(ready3),
    .d_data(d_data3), .d_id(d_id3), .d_valid(d_valid3), .d_ready(d_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pay(input int k);
    return 32'hC0DE_0000 + DW'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out1(input string tag, input logic v, input int id);
    chk({tag, ".valid"}, 64'(d_valid1), 64'(v));
    chk({tag, ".id"},    64'(d_id1),    64'(id));
    chk({tag, ".data"},  64'(d_data1),  64'(pay(id)));
  endtask

  task automatic chk_out3(input string tag, input int id);
    chk({tag, ".valid"}, 64'(d_valid3), 64'd1);
    chk({tag, ".id"},    64'(d_id3),    64'(id));
    chk({tag, ".data"},  64'(d_data3),  64'(pay(id)));
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    valid1 = '0; d_ready1 = 1'b0;
    valid3 = '0; d_ready3 = 1'b0;
    for (int k = 0; k < NR; k++) req_data[k*DW +: DW] = pay(k);
    #2;
    chk("rst.valid", 64'(d_valid1), 64'd0);
    chk("rst.data",  64'(d_data1),  64'd0);
    chk("rst.id",    64'(d_id1),    64'd0);
    chk("rst.ready", 64'(ready1),   64'd0);
    tick();
    rst = 1'b0;

    // All four valid, strict round-robin: 0,1,2,3,0.
    valid1 = 4'b1111;
    d_ready1 = 1'b1;
    #1;
    chk("rr.ready0", 64'(ready1),   64'b0001);
    chk("rr.pre",    64'(d_valid1), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out1($sformatf("rr%0d", i), 1'b1, i % NR);
    end
    chk("rr.ready1", 64'(ready1), 64'b0010);

    // Grant requester 1, then stall three cycles.
    tick();
    chk_out1("pre_stall", 1'b1, 1);
    d_ready1 = 1'b0;
    #1;
    chk("stall.ready", 64'(ready1), 64'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out1($sformatf("stall%0d", i), 1'b1, 1);
      chk($sformatf("stall%0d.ready", i), 64'(ready1), 64'b0000);
    end
    d_ready1 = 1'b1;
    #1;
    chk("unstall.ready", 64'(ready1), 64'b0100);
    tick();
    chk_out1("unstall", 1'b1, 2);

    // Only requester 2, pointer at 3: three back-to-back grants.
    valid1 = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out1($sformatf("solo%0d", i), 1'b1, 2);
    end
    // Requester 1 joins with pointer at 3: the search wraps to 1, then 2.
    valid1 = 4'b0110;
    tick();
    chk_out1("wrap0", 1'b1, 1);
    tick();
    chk_out1("wrap1", 1'b1, 2);
    // Nothing valid: d_valid drops while d_data and d_id hold.
    valid1 = 4'b0000;
    #1;
    chk("idle.ready", 64'(ready1), 64'b0000);
    tick();
    chk_out1("idle", 1'b0, 2);

    // Bursts of three with requesters 0 and 1: 0,0,0,1,1,1,0.
    valid3 = 4'b0011;
    d_ready3 = 1'b1;
    begin
      int seq[7] = '{0, 0, 0, 1, 1, 1, 0};
      for (int i = 0; i < 7; i++) begin
        tick();
        chk_out3($sformatf("burst%0d", i), seq[i]);
      end
    end

    // Requester 0 is granted once and drops out; requester 1 then gets a full burst of three.
    rst = 1'b1;
    valid3 = 4'b0000;
    tick();
    rst = 1'b0;
    valid3 = 4'b0001;
    tick();
    chk_out3("fresh0", 0);
    valid3 = 4'b0010;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_out3($sformatf("fresh%0d", i), 1);
    end
    // The pointer is now 2, so the search 2,3,0 lands on requester 0.
    valid3 = 4'b0011;
    tick();
    chk_out3("fresh.ptr2", 0);

    // Reset mid-stream: the output register clears at once, without waiting for an edge.
    valid1 = 4'b1111;
    tick();
    tick();
    chk("pre_arst.valid", 64'(d_valid1), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.valid", 64'(d_valid1), 64'd0);
    chk("arst.data",  64'(d_data1),  64'd0);
    chk("arst.id",    64'(d_id1),    64'd0);
    chk("arst.valid3", 64'(d_valid3), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_arst.ready", 64'(ready1), 64'b0001);
    tick();
    chk_out1("post_arst", 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
